// File: rtl/mux_scan_pkg.sv
// Shared constants, state encodings and the lowest-channel helper for the mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Lowest enabled channel; returns 0 for an empty mask, which callers must screen out.
    function automatic logic [SEL_W-1:0] first_ch(input logic [NUM_CH-1:0] mask);
        logic [SEL_W-1:0] result;
        result = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                result = SEL_W'(i);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above the current one.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [SEL_W-1:0]  i_ch,
    output logic [SEL_W-1:0]  o_next_ch,
    output logic              o_has_next
);

    // Scanning downward lets the lowest qualifying channel win the last assignment.
    always_comb begin
        o_next_ch  = i_ch;
        o_has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((i > int'(i_ch)) && i_mask[i]) begin
                o_next_ch  = SEL_W'(i);
                o_has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4:1 mux select through the enabled channels, samples y after a settle period,
// and offers the packed frame downstream on a valid/ready handshake.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC   = 2,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NUM_CH-1:0] i_ch_mask,
    output logic              o_s0,
    output logic              o_s1,
    input  logic              i_y_in,
    output logic [NUM_CH-1:0] o_frame,
    output logic              o_frame_valid,
    input  logic              i_frame_ready,
    output logic              o_busy
);

    if ((SETTLE_CYC < 1) || (SETTLE_CYC > 15)) begin : g_bad_settle
        $error("mux_scan_sequencer: SETTLE_CYC must be in 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

    logic [1:0]        r_state;
    logic [NUM_CH-1:0] r_mask_q;
    logic [SEL_W-1:0]  r_ch;
    logic [CNT_W-1:0]  r_cnt;
    logic [NUM_CH-1:0] r_acc;
    logic [NUM_CH-1:0] r_frame;
    logic              r_valid;

    logic [NUM_CH-1:0] w_first_mask;
    logic [SEL_W-1:0]  w_first_ch;
    logic [SEL_W-1:0]  w_next_ch;
    logic              w_has_next;
    logic [NUM_CH-1:0] w_acc_upd;

    // A fresh scan takes its mask from the port in IDLE and from the captured copy on restart.
    assign w_first_mask = (r_state == ST_IDLE) ? i_ch_mask : r_mask_q;
    assign w_first_ch   = first_ch(w_first_mask);
    assign w_acc_upd    = r_acc | (NUM_CH'(i_y_in) << r_ch);

    mux_scan_next_ch u_next_ch (
        .i_mask     (r_mask_q),
        .i_ch       (r_ch),
        .o_next_ch  (w_next_ch),
        .o_has_next (w_has_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_mask_q <= '0;
            r_ch     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_frame  <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_mask_q <= i_ch_mask;
                        r_acc    <= '0;
                        if (|i_ch_mask) begin
                            r_ch    <= w_first_ch;
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_frame <= '0;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    r_acc <= w_acc_upd;
                    if (w_has_next) begin
                        r_ch    <= w_next_ch;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_SETTLE;
                    end else begin
                        r_frame <= w_acc_upd;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Entering DONE with valid low only happens for an empty mask.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (i_frame_ready) begin
                        r_valid <= 1'b0;
                        if (AUTO_RESTART && (|r_mask_q)) begin
                            r_acc   <= '0;
                            r_ch    <= w_first_ch;
                            r_cnt   <= CNT_LOAD;
                            r_state <= ST_SETTLE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_s0          = r_ch[0];
    assign o_s1          = r_ch[1];
    assign o_frame       = r_frame;
    assign o_frame_valid = r_valid;
    assign o_busy        = (r_state != ST_IDLE);

endmodule
